// File: rtl/posit_normalize_pkg.sv
// Shared constants and stage records for the posit encoder (posit_normalize).
// Build option POSIT_ROUND_NEAREST_EN selects round-to-nearest-even over truncation in posit_round.
package posit_normalize_pkg;

  localparam int NBITS     = 32;
  localparam int ES        = 2;
  localparam int FBITS     = NBITS - ES - 3;
  localparam int MAX_SCALE = (NBITS - 2) << ES;
  localparam int KW        = 6;  // holds k in [-30, +30]

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              inf;
    logic signed [7:0] scale;
    logic [FBITS-1:0]  fraction;
  } value_t;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               inf;
    logic signed [KW-1:0] k;
    logic [ES-1:0]      e;
    logic [FBITS-1:0]   fraction;
  } norm_s1;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             inf;
    logic [NBITS-2:0] body;
    logic             guard;
    logic             sticky;
  } norm_s2;

  function automatic logic signed [7:0] clamp_scale(input logic signed [7:0] s);
    int si;
    si = s;
    if (si > MAX_SCALE)       return 8'(MAX_SCALE);
    else if (si < -MAX_SCALE) return 8'(-MAX_SCALE);
    else                      return s;
  endfunction

endpackage

// File: rtl/posit_normalize_if.sv
// Stream interface of the posit encoder: decoded value in, packed posit out.
interface posit_normalize_if;
  import posit_normalize_pkg::*;

  // Each side transfers on a clock edge where its valid and ready are both high;
  // valid never waits for ready, and payload is held stable while valid & ~ready.
  logic             in_valid;
  logic             in_ready;
  value_t           in_value;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_posit;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_posit
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_posit
  );

endinterface

// File: rtl/posit_round.sv
// Final encode stage: rounding, minpos/maxpos fix-up, negation and special values.
// POSIT_ROUND_NEAREST_EN defined: round to nearest-even; undefined: truncate magnitude.
module posit_round
  import posit_normalize_pkg::*;
(
  input  norm_s2           s2,
  output logic [NBITS-1:0] posit
);

  logic             inc;
  logic [NBITS-2:0] body_r;
  logic [NBITS-1:0] mag;

`ifdef POSIT_ROUND_NEAREST_EN
  // Incrementing maxpos would wrap the regime, so saturate there instead.
  assign inc = s2.guard & (s2.sticky | s2.body[0]) & ~(&s2.body);
`else
  logic unused_rnd;
  assign unused_rnd = s2.guard ^ s2.sticky;
  assign inc        = 1'b0;
`endif

  always_comb begin
    body_r = s2.body + {{(NBITS-2){1'b0}}, inc};
    if (~|body_r) body_r = {{(NBITS-2){1'b0}}, 1'b1};
    mag   = {1'b0, body_r};
    posit = s2.sign ? -mag : mag;
    if (s2.inf)       posit = {1'b1, {(NBITS-1){1'b0}}};
    else if (s2.zero) posit = '0;
  end

endmodule

// File: rtl/posit_normalize.sv
// Three-stage posit encoder: clamp/split, regime assembly, round/sign.
// Rounding mode is chosen by POSIT_ROUND_NEAREST_EN inside posit_round.
module posit_normalize
  import posit_normalize_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  posit_normalize_if.slave   bus
);

  localparam int SW = 2 * NBITS;

  logic             adv;
  logic             v1, v2, v3;
  norm_s1           s1_d, s1_q;
  norm_s2           s2_d, s2_q;
  logic [NBITS-1:0] round_out, out_q;

  logic signed [7:0] sc;
  logic [SW-1:0]     pat;
  logic [SW-1:0]     str;
  logic [KW-1:0]     shamt;

  // Every stage moves in lockstep, so the whole pipe freezes while the output waits.
  assign adv           = ~v3 | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;
  assign bus.out_posit = out_q;

  always_comb begin
    sc            = clamp_scale(bus.in_value.scale);
    s1_d.sign     = bus.in_value.sign;
    s1_d.zero     = bus.in_value.zero;
    s1_d.inf      = bus.in_value.inf;
    s1_d.k        = KW'(sc >>> ES);
    s1_d.e        = sc[ES-1:0];
    s1_d.fraction = bus.in_value.fraction;
  end

  // The regime comes from arithmetic-shifting a 2-bit seed: "10" smears ones for
  // k>=0, "01" smears zeros for k<0 (shift by ~k, i.e. -k-1).
  always_comb begin
    if (!s1_q.k[KW-1]) begin
      pat   = {2'b10, s1_q.e, s1_q.fraction, {(SW-2-ES-FBITS){1'b0}}};
      shamt = s1_q.k;
    end else begin
      pat   = {2'b01, s1_q.e, s1_q.fraction, {(SW-2-ES-FBITS){1'b0}}};
      shamt = ~s1_q.k;
    end
    str         = $signed(pat) >>> shamt;
    s2_d.sign   = s1_q.sign;
    s2_d.zero   = s1_q.zero;
    s2_d.inf    = s1_q.inf;
    s2_d.body   = str[SW-1 -: NBITS-1];
    s2_d.guard  = str[SW-NBITS];
    s2_d.sticky = |str[SW-NBITS-1:0];
  end

  posit_round u_round (
    .s2    (s2_q),
    .posit (round_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else if (adv) begin
      v1    <= bus.in_valid;
      s1_q  <= s1_d;
      v2    <= v1;
      s2_q  <= s2_d;
      v3    <= v2;
      out_q <= round_out;
    end
  end

endmodule

// File: tb/tb_posit_normalize.sv
// Scoreboard bench for posit_normalize: directed vectors, stalls, reset flush.
module tb_posit_normalize;
  import posit_normalize_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [NBITS-1:0] exp_q[$];
  value_t           vec_v[$];
  logic [NBITS-1:0] vec_e[$];

`ifdef POSIT_ROUND_NEAREST_EN
  localparam logic [31:0] E_S4_F3   = 32'h60000002;
  localparam logic [31:0] E_S8_F3   = 32'h70000001;
  localparam logic [31:0] E_S8_F6   = 32'h70000002;
  localparam logic [31:0] E_S119    = 32'h7FFFFFFF;
`else
  localparam logic [31:0] E_S4_F3   = 32'h60000001;
  localparam logic [31:0] E_S8_F3   = 32'h70000000;
  localparam logic [31:0] E_S8_F6   = 32'h70000001;
  localparam logic [31:0] E_S119    = 32'h7FFFFFFE;
`endif

  posit_normalize_if bus ();

  posit_normalize dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic value_t mk(input logic s, input logic z, input logic i,
                                input int scale, input logic [FBITS-1:0] f);
    value_t v;
    v.sign     = s;
    v.zero     = z;
    v.inf      = i;
    v.scale    = 8'(scale);
    v.fraction = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver
  task automatic send(input value_t v, input logic [NBITS-1:0] e);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    #1;
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic add(input value_t v, input logic [NBITS-1:0] e);
    vec_v.push_back(v);
    vec_e.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor / scoreboard: looks at the values that will be sampled at the next posedge
  always @(negedge clk) begin
    logic [NBITS-1:0] e;
    #2;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", bus.out_posit);
      end else begin
        e = exp_q.pop_front();
        check("out_posit", bus.out_posit, e);
      end
    end
  end

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_posit", bus.out_posit, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // latency of a single item with no stall
    send(mk(0, 0, 0, 0, '0), 32'h40000000);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check("latency", 32'(lat), 32'd3);
    drain();

    add(mk(1, 0, 0, 0, '0), 32'hC0000000);
    add(mk(0, 0, 0, 5, '0), 32'h64000000);
    add(mk(0, 1, 0, 5, '0), 32'h00000000);
    add(mk(0, 0, 1, 5, '0), 32'h80000000);
    add(mk(1, 1, 1, 3, '0), 32'h80000000);
    add(mk(0, 0, 0, 127, '0), 32'h7FFFFFFF);
    add(mk(0, 0, 0, -128, '0), 32'h00000001);
    add(mk(1, 0, 0, -128, '0), 32'hFFFFFFFF);
    add(mk(0, 0, 0, -119, '0), 32'h00000001);
    add(mk(0, 0, 0, -1, '0), 32'h38000000);
    add(mk(1, 0, 0, 0, 27'h4000000), 32'hBC000000);
    add(mk(0, 0, 0, 4, 27'h1), 32'h60000000);
    add(mk(0, 0, 0, 4, 27'h3), E_S4_F3);
    add(mk(0, 0, 0, 8, 27'h2), 32'h70000000);
    add(mk(0, 0, 0, 8, 27'h3), E_S8_F3);
    add(mk(0, 0, 0, 8, 27'h6), E_S8_F6);
    add(mk(0, 0, 0, 119, '0), E_S119);
    add(mk(0, 0, 0, 120, 27'h7FFFFFF), 32'h7FFFFFFF);

    // back-to-back with steady out_ready
    foreach (vec_v[i]) send(vec_v[i], vec_e[i]);
    drain();

    // same vectors under a random out_ready pattern
    fork
      begin
        foreach (vec_v[i]) send(vec_v[i], vec_e[i]);
      end
      begin
        repeat (80) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // backpressure: three accepts fill the pipe
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(mk(0, 0, 0, 0, '0), 32'h40000000);
    send(mk(0, 0, 0, 5, '0), 32'h64000000);
    send(mk(1, 0, 0, 0, '0), 32'hC0000000);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = mk(0, 0, 0, -1, '0);
    #1;
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_head", bus.out_posit, 32'h40000000);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(mk(0, 0, 0, -1, '0), 32'h38000000);
    send(mk(0, 0, 1, 0, '0), 32'h80000000);
    drain();

    // reset with two items in flight: they must vanish
    send(mk(0, 0, 0, 5, '0), 32'h64000000);
    send(mk(0, 0, 0, 4, '0), 32'h60000000);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_out_posit", bus.out_posit, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_no_stale", {31'd0, bus.out_valid}, 32'd0);

    send(mk(0, 0, 0, 127, '0), 32'h7FFFFFFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_normalize.md
Name: posit_normalize

Overview:
- Encoder counterpart of the posit field extractor: takes a decoded `value` (sign, zero, inf, scale, fraction) from the arithmetic datapath and packs it back into an NBITS-bit posit.
- Packing covers clamping, regime construction, rounding and two's-complement negation.
- 3-stage pipeline with valid/ready handshake; sits at the output of each posit adder/multiplier in the PairHMM datapath.

Parameters:
- NBITS, 32, posit width (posit_defines package constant, not overridden per instance).
- ES, 2, exponent field width (posit_defines package constant).
- FBITS, NBITS-ES-3 = 27, fraction width of `value.fraction`, hidden bit excluded (package constant).
- MAX_SCALE, (NBITS-2)<<ES = 120, scale of maxpos; minpos scale = -MAX_SCALE (package constant).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input value valid
- in_ready  out  1  block accepts input this cycle
- in_value  in  value  decoded posit (sign, zero, inf, scale[7:0] signed, fraction[FBITS-1:0])
- out_valid  out  1  out_posit valid
- out_ready  in  1  downstream accepts output
- out_posit  out  NBITS  encoded posit

Behaviour:
- Reset values: out_valid=0, out_posit=0, all stage valid bits 0. in_ready=1 during and after reset.
- Stall: `adv = ~out_valid | out_ready`. in_ready = adv. All three stages advance together when adv=1 and freeze otherwise.
- Transfer: input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
- Latency: 3 cycles accept-to-out_valid without stall. Throughput 1/cycle. Capacity 3 items. No drop, no duplication under any out_ready pattern.
- Stage 1, clamp/split:
  - scale clamped to [-120, +120].
  - k = scale >>> ES (arithmetic). e = scale[ES-1:0].
  - Regime length: k+2 for k≥0, -k+1 for k<0.
  - zero, inf and sign pass through.
- Stage 2, assemble:
  - Build 2*NBITS-bit string, MSB first: regime (k≥0: k+1 ones then 0; k<0: -k zeros then 1), then e, then fraction, then zeros.
  - body = top NBITS-1 bits. guard = next bit. sticky = OR of all remaining bits.
- Stage 3, round/sign:
  - Increment body iff guard & (sticky | body[0]) (round to nearest, ties to even).
  - Never increment when body is all ones (maxpos).
  - A body of all zeros after rounding becomes 1 (minpos); posit results never round to zero.
  - Result = {1'b0, body}; two's complement if sign.
  - zero → 0x00000000; inf → 0x80000000; inf has priority over zero.
- Reset mid-operation: all in-flight items discarded at the reset edge; no output generated for them.
- Simultaneous in/out handshake while full: one item leaves, one enters the same cycle.

Optional Feature:
- Macro POSIT_ROUND_NEAREST_EN.
- Defined: stage 3 rounds to nearest-even as above.
- Undefined: guard and sticky are ignored (truncation of magnitude). The minpos and maxpos rules still apply.
- Latency and handshake are identical in both builds.

Decomposition:
- posit_defines additions:
  - constants FBITS and MAX_SCALE.
  - typedef `norm_s1` (sign, zero, inf, k, e, fraction).
  - typedef `norm_s2` (sign, zero, inf, body, guard, sticky).
- Sub-module posit_round: combinational stage-3 logic (round, minpos/maxpos fix-up, negate, specials). It contains the POSIT_ROUND_NEAREST_EN branch.
- Pipeline registers and stall control live in posit_normalize.

Test Plan:
- scale=0, fraction=0, sign=0 → 0x40000000 three cycles later. Same with sign=1 → 0xC0000000.
- scale=5, fraction=0 → 0x64000000. zero=1 → 0x00000000. inf=1 → 0x80000000.
- Clamp: scale=127 → 0x7FFFFFFF. scale=-128 → 0x00000001.
- Rounding at scale=4:
  - fraction=27'h1 → 0x60000000 (tie, even).
  - fraction=27'h3 → 0x60000002 with macro, 0x60000001 without.
- Backpressure: out_ready=0, issue 5 inputs → in_ready falls after 3 accepts. Release out_ready → all 3 accepted items emerge in order, then the remaining 2 are accepted, 1/cycle.
- Assert reset with 2 items in flight → out_valid=0 next cycle, no stale output after reset release.
